// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared ALU opcode and operand-select encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam logic [4:0] ALUOp_nop   = 5'd0;
    localparam logic [4:0] ALUOp_lui   = 5'd1;
    localparam logic [4:0] ALUOp_auipc = 5'd2;
    localparam logic [4:0] ALUOp_add   = 5'd3;
    localparam logic [4:0] ALUOp_sub   = 5'd4;

    typedef enum logic [1:0] {
        ASEL_RS1  = 2'b00,
        ASEL_PC   = 2'b01,
        ASEL_ZERO = 2'b10,
        ASEL_RSVD = 2'b11
    } a_sel_e;

    typedef enum logic {
        BSEL_RS2 = 1'b0,
        BSEL_IMM = 1'b1
    } b_sel_e;

endpackage
`default_nettype wire

// File: rtl/id_ex_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_stage_if
//  Description : Decode-side, forwarding and execute-side bundle of the ID/EX stage.
//  Revision    : 1.0 - initial release
// ============================================================================
interface id_ex_stage_if #(
    parameter int XLEN = 32
);
    import cpu_pkg::*;

    logic                   in_valid;
    logic                   in_ready;
    logic [XLEN-1:0]        in_pc;
    logic [XLEN-1:0]        in_rs1_data;
    logic [XLEN-1:0]        in_rs2_data;
    logic [XLEN-1:0]        in_imm;
    logic [4:0]             in_rs1;
    logic [4:0]             in_rs2;
    logic [4:0]             in_rd;
    logic [4:0]             in_alu_op;
    logic [1:0]             in_a_sel;
    logic                   in_b_sel;
    logic                   in_reg_write;
    logic                   flush;
    logic                   exmem_reg_write;
    logic [4:0]             exmem_rd;
    logic [XLEN-1:0]        exmem_result;
    logic                   memwb_reg_write;
    logic [4:0]             memwb_rd;
    logic [XLEN-1:0]        memwb_result;
    logic                   out_valid;
    logic                   out_ready;
    logic signed [XLEN-1:0] A;
    logic signed [XLEN-1:0] B;
    logic [4:0]             ALUOp;
    logic [4:0]             out_rd;
    logic                   out_reg_write;

    modport master (
        output in_valid, in_pc, in_rs1_data, in_rs2_data, in_imm,
               in_rs1, in_rs2, in_rd, in_alu_op, in_a_sel, in_b_sel,
               in_reg_write, flush,
               exmem_reg_write, exmem_rd, exmem_result,
               memwb_reg_write, memwb_rd, memwb_result, out_ready,
        input  in_ready, out_valid, A, B, ALUOp, out_rd, out_reg_write
    );

    modport slave (
        input  in_valid, in_pc, in_rs1_data, in_rs2_data, in_imm,
               in_rs1, in_rs2, in_rd, in_alu_op, in_a_sel, in_b_sel,
               in_reg_write, flush,
               exmem_reg_write, exmem_rd, exmem_result,
               memwb_reg_write, memwb_rd, memwb_result, out_ready,
        output in_ready, out_valid, A, B, ALUOp, out_rd, out_reg_write
    );

endinterface
`default_nettype wire

// File: rtl/fwd_mux.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_mux
//  Description : Resolves one source operand from EX/MEM, MEM/WB or the register
//                file. Forwarding is built only when ID_EX_FWD_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module fwd_mux
    import cpu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  wire logic [4:0]      i_idx,
    input  wire logic [XLEN-1:0] i_reg_data,
    input  wire logic            i_exmem_we,
    input  wire logic [4:0]      i_exmem_rd,
    input  wire logic [XLEN-1:0] i_exmem_data,
    input  wire logic            i_memwb_we,
    input  wire logic [4:0]      i_memwb_rd,
    input  wire logic [XLEN-1:0] i_memwb_data,
    output logic      [XLEN-1:0] o_data
);

`ifdef ID_EX_FWD_EN
    logic w_hit_exmem;
    logic w_hit_memwb;

    // x0 is hard-wired zero, so a producer targeting it must never be forwarded
    assign w_hit_exmem = (i_idx != 5'd0) && i_exmem_we && (i_exmem_rd == i_idx);
    assign w_hit_memwb = (i_idx != 5'd0) && i_memwb_we && (i_memwb_rd == i_idx);

    always_comb begin
        o_data = i_reg_data;
        if (w_hit_exmem) begin
            o_data = i_exmem_data;
        end else if (w_hit_memwb) begin
            o_data = i_memwb_data;
        end
    end
`else
    logic w_unused;
    assign w_unused = ^{i_idx, i_exmem_we, i_exmem_rd, i_exmem_data,
                        i_memwb_we, i_memwb_rd, i_memwb_data};
    assign o_data   = i_reg_data;
`endif

endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_stage
//  Description : ID/EX pipeline register with operand selection, optional
//                forwarding (ID_EX_FWD_EN), stall and flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  wire logic     clk,
    input  wire logic     rst,
    id_ex_stage_if.slave  bus
);

    logic            w_in_ready;
    logic            w_capture;
    logic [XLEN-1:0] w_rs1_val;
    logic [XLEN-1:0] w_rs2_val;
    logic [XLEN-1:0] w_a_next;
    logic [XLEN-1:0] w_b_next;

    logic            r_out_valid;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [4:0]      r_alu_op;
    logic [4:0]      r_rd;
    logic            r_reg_write;

    assign w_in_ready = !r_out_valid || bus.out_ready;
    assign w_capture  = bus.in_valid && w_in_ready && !bus.flush;

    fwd_mux #(.XLEN(XLEN)) u_fwd_rs1 (
        .i_idx        (bus.in_rs1),
        .i_reg_data   (bus.in_rs1_data),
        .i_exmem_we   (bus.exmem_reg_write),
        .i_exmem_rd   (bus.exmem_rd),
        .i_exmem_data (bus.exmem_result),
        .i_memwb_we   (bus.memwb_reg_write),
        .i_memwb_rd   (bus.memwb_rd),
        .i_memwb_data (bus.memwb_result),
        .o_data       (w_rs1_val)
    );

    fwd_mux #(.XLEN(XLEN)) u_fwd_rs2 (
        .i_idx        (bus.in_rs2),
        .i_reg_data   (bus.in_rs2_data),
        .i_exmem_we   (bus.exmem_reg_write),
        .i_exmem_rd   (bus.exmem_rd),
        .i_exmem_data (bus.exmem_result),
        .i_memwb_we   (bus.memwb_reg_write),
        .i_memwb_rd   (bus.memwb_rd),
        .i_memwb_data (bus.memwb_result),
        .o_data       (w_rs2_val)
    );

    always_comb begin
        w_a_next = '0;
        case (bus.in_a_sel)
            ASEL_RS1: w_a_next = w_rs1_val;
            ASEL_PC:  w_a_next = bus.in_pc;
            default:  w_a_next = '0;
        endcase
        w_b_next = (bus.in_b_sel == BSEL_IMM) ? bus.in_imm : w_rs2_val;
    end

    // Flush outranks capture; payload registers hold whenever nothing is captured
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_alu_op    <= ALUOp_nop;
            r_rd        <= 5'd0;
            r_reg_write <= 1'b0;
        end else if (bus.flush) begin
            r_out_valid <= 1'b0;
        end else if (w_capture) begin
            r_out_valid <= 1'b1;
            r_a         <= w_a_next;
            r_b         <= w_b_next;
            r_alu_op    <= bus.in_alu_op;
            r_rd        <= bus.in_rd;
            r_reg_write <= bus.in_reg_write;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready      = w_in_ready;
    assign bus.out_valid     = r_out_valid;
    assign bus.A             = r_a;
    assign bus.B             = r_b;
    assign bus.ALUOp         = r_alu_op;
    assign bus.out_rd        = r_rd;
    assign bus.out_reg_write = r_reg_write;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_ex_stage
//  Description : Self-checking bench for id_ex_stage (honours ID_EX_FWD_EN).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;
    import cpu_pkg::*;

    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;

    id_ex_stage_if #(.XLEN(XLEN)) bus ();

    id_ex_stage #(.XLEN(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Reference: what the stage must hold after each edge
    logic        m_valid = 1'b0;
    logic [31:0] m_a     = '0;
    logic [31:0] m_b     = '0;
    logic [4:0]  m_op    = '0;
    logic [4:0]  m_rd    = '0;
    logic        m_rw    = 1'b0;

    function automatic logic [31:0] resolve(input logic [4:0] r, input logic [31:0] d);
        if (r == 5'd0) return d;
`ifdef ID_EX_FWD_EN
        if (bus.exmem_reg_write && bus.exmem_rd == r) return bus.exmem_result;
        if (bus.memwb_reg_write && bus.memwb_rd == r) return bus.memwb_result;
`endif
        return d;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_a     <= '0;
            m_b     <= '0;
            m_op    <= 5'd0;
            m_rd    <= 5'd0;
            m_rw    <= 1'b0;
        end else if (bus.flush) begin
            m_valid <= 1'b0;
        end else if (bus.in_valid && (!m_valid || bus.out_ready)) begin
            m_valid <= 1'b1;
            m_a     <= (bus.in_a_sel == 2'b00) ? resolve(bus.in_rs1, bus.in_rs1_data) :
                       (bus.in_a_sel == 2'b01) ? bus.in_pc : 32'd0;
            m_b     <= bus.in_b_sel ? bus.in_imm : resolve(bus.in_rs2, bus.in_rs2_data);
            m_op    <= bus.in_alu_op;
            m_rd    <= bus.in_rd;
            m_rw    <= bus.in_reg_write;
        end else if (bus.out_ready) begin
            m_valid <= 1'b0;
        end
        #1;
        check("mdl_out_valid", 32'(bus.out_valid), 32'(m_valid));
        check("mdl_in_ready",  32'(bus.in_ready),  32'(!m_valid || bus.out_ready));
        check("mdl_A",         32'(bus.A),         m_a);
        check("mdl_B",         32'(bus.B),         m_b);
        check("mdl_ALUOp",     32'(bus.ALUOp),     32'(m_op));
        check("mdl_out_rd",    32'(bus.out_rd),    32'(m_rd));
        check("mdl_out_rw",    32'(bus.out_reg_write), 32'(m_rw));
    end

    task automatic idle_inputs();
        bus.in_valid        = 1'b0;
        bus.in_pc           = '0;
        bus.in_rs1_data     = '0;
        bus.in_rs2_data     = '0;
        bus.in_imm          = '0;
        bus.in_rs1          = '0;
        bus.in_rs2          = '0;
        bus.in_rd           = '0;
        bus.in_alu_op       = '0;
        bus.in_a_sel        = '0;
        bus.in_b_sel        = 1'b0;
        bus.in_reg_write    = 1'b0;
        bus.flush           = 1'b0;
        bus.exmem_reg_write = 1'b0;
        bus.exmem_rd        = '0;
        bus.exmem_result    = '0;
        bus.memwb_reg_write = 1'b0;
        bus.memwb_rd        = '0;
        bus.memwb_result    = '0;
        bus.out_ready       = 1'b1;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    initial begin
        idle_inputs();
        // Reset held while decode offers an instruction
        bus.in_valid    = 1'b1;
        bus.in_alu_op   = ALUOp_add;
        bus.in_rs1_data = 32'h55;
        bus.in_rs2_data = 32'h66;
        repeat (2) after_edge();
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_A",         32'(bus.A),         32'd0);
        check("rst_B",         32'(bus.B),         32'd0);
        check("rst_ALUOp",     32'(bus.ALUOp),     32'd0);

        @(negedge clk);
        rst = 1'b0;
        idle_inputs();

        // Forward priority on rs1
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_alu_op = ALUOp_add; bus.in_rs1 = 5'd5;
        bus.in_rs1_data = 32'h33; bus.in_rs2_data = 32'h4; bus.in_rd = 5'd7;
        bus.in_reg_write = 1'b1;
        bus.exmem_reg_write = 1'b1; bus.exmem_rd = 5'd5; bus.exmem_result = 32'h11;
        bus.memwb_reg_write = 1'b1; bus.memwb_rd = 5'd5; bus.memwb_result = 32'h22;
        after_edge();
`ifdef ID_EX_FWD_EN
        check("fwd_prio_A", 32'(bus.A), 32'h11);
`else
        check("fwd_prio_A", 32'(bus.A), 32'h33);
`endif
        check("fwd_prio_valid", 32'(bus.out_valid), 32'd1);
        check("fwd_prio_rd",    32'(bus.out_rd),    32'd7);

        // x0 never forwarded
        @(negedge clk);
        bus.in_rs2 = 5'd0; bus.in_rs2_data = 32'h0; bus.in_b_sel = 1'b0;
        bus.exmem_rd = 5'd0; bus.exmem_result = 32'hFF;
        bus.memwb_reg_write = 1'b0;
        after_edge();
        check("x0_guard_B", 32'(bus.B), 32'd0);

        // Capture sub 7,3 then stall three cycles with fresh inputs
        @(negedge clk);
        idle_inputs();
        bus.in_valid = 1'b1; bus.in_alu_op = ALUOp_sub;
        bus.in_rs1 = 5'd1; bus.in_rs1_data = 32'd7;
        bus.in_rs2 = 5'd2; bus.in_rs2_data = 32'd3;
        after_edge();
        check("stall_cap_A", 32'(bus.A), 32'd7);
        check("stall_cap_B", 32'(bus.B), 32'd3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.out_ready = 1'b0; bus.in_alu_op = ALUOp_add;
            bus.in_rs1_data = 32'h99 + 32'(i); bus.in_rs2_data = 32'h44;
            #1;
            check("stall_in_ready", 32'(bus.in_ready), 32'd0);
            after_edge();
            check("stall_A",     32'(bus.A),         32'd7);
            check("stall_B",     32'(bus.B),         32'd3);
            check("stall_ALUOp", 32'(bus.ALUOp),     32'd4);
            check("stall_valid", 32'(bus.out_valid), 32'd1);
        end
        @(negedge clk);
        bus.out_ready = 1'b1; bus.in_rs1_data = 32'd9; bus.in_rs2_data = 32'd1;
        after_edge();
        check("release_A",     32'(bus.A),     32'd9);
        check("release_B",     32'(bus.B),     32'd1);
        check("release_ALUOp", 32'(bus.ALUOp), 32'd3);

        // Flush wins over a live handshake
        @(negedge clk);
        bus.flush = 1'b1; bus.in_alu_op = ALUOp_sub; bus.in_rs1_data = 32'h77;
        after_edge();
        check("flush_valid", 32'(bus.out_valid), 32'd0);
        check("flush_A",     32'(bus.A),         32'd9);

        // auipc then lui
        @(negedge clk);
        idle_inputs();
        bus.in_valid = 1'b1; bus.in_pc = 32'h1000; bus.in_imm = 32'h2000;
        bus.in_a_sel = 2'b01; bus.in_b_sel = 1'b1; bus.in_alu_op = ALUOp_auipc;
        after_edge();
        check("auipc_A",     32'(bus.A),     32'h1000);
        check("auipc_B",     32'(bus.B),     32'h2000);
        check("auipc_ALUOp", 32'(bus.ALUOp), 32'd2);
        @(negedge clk);
        bus.in_a_sel = 2'b10; bus.in_alu_op = ALUOp_lui;
        after_edge();
        check("lui_A",     32'(bus.A),     32'h0);
        check("lui_B",     32'(bus.B),     32'h2000);
        check("lui_ALUOp", 32'(bus.ALUOp), 32'd1);

        // Async reset in the middle of a stall
        @(negedge clk);
        idle_inputs();
        bus.in_valid = 1'b1; bus.in_alu_op = ALUOp_add; bus.in_rs1_data = 32'h5;
        after_edge();
        @(negedge clk);
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        after_edge();
        @(negedge clk);
        rst = 1'b1;
        #2;
        check("async_rst_valid", 32'(bus.out_valid), 32'd0);
        check("async_rst_A",     32'(bus.A),         32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.in_valid = 1'b1; bus.in_rs1_data = 32'h66;
        after_edge();
        check("post_rst_valid", 32'(bus.out_valid), 32'd1);
        check("post_rst_A",     32'(bus.A),         32'h66);

        // Randomized traffic with a small register window to provoke forwarding
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            bus.in_valid        = ($urandom_range(0, 3) != 0);
            bus.out_ready       = ($urandom_range(0, 3) != 0);
            bus.flush           = ($urandom_range(0, 9) == 0);
            bus.in_pc           = $urandom;
            bus.in_rs1_data     = $urandom;
            bus.in_rs2_data     = $urandom;
            bus.in_imm          = $urandom;
            bus.in_rs1          = 5'($urandom_range(0, 3));
            bus.in_rs2          = 5'($urandom_range(0, 3));
            bus.in_rd           = 5'($urandom_range(0, 31));
            bus.in_alu_op       = 5'($urandom_range(0, 4));
            bus.in_a_sel        = 2'($urandom_range(0, 3));
            bus.in_b_sel        = 1'($urandom_range(0, 1));
            bus.in_reg_write    = 1'($urandom_range(0, 1));
            bus.exmem_reg_write = 1'($urandom_range(0, 1));
            bus.exmem_rd        = 5'($urandom_range(0, 3));
            bus.exmem_result    = $urandom;
            bus.memwb_reg_write = 1'($urandom_range(0, 1));
            bus.memwb_rd        = 5'($urandom_range(0, 3));
            bus.memwb_result    = $urandom;
        end

        @(negedge clk);
        idle_inputs();
        repeat (2) after_edge();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline register feeding the `alu` block. It accepts one decoded instruction per cycle through a valid/ready handshake and resolves operand sources (register, PC, immediate, zero). It applies EX/MEM and MEM/WB forwarding, then registers `A`, `B` and `ALUOp` so the ALU sees stable operands for a full cycle. It supports stall (downstream not ready) and flush (branch/exception kill).

## Interface
- `XLEN`, default 32: operand and PC width.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  decode holds a valid instruction.
- `in_ready`  out  1  stage can accept this cycle.
- `in_pc`  in  XLEN  instruction PC.
- `in_rs1_data`, `in_rs2_data`  in  XLEN  register-file read data.
- `in_imm`  in  XLEN  sign-extended or shifted immediate.
- `in_rs1`, `in_rs2`, `in_rd`  in  5  register indices.
- `in_alu_op`  in  5  ALU opcode (nop/lui/auipc/add/sub).
- `in_a_sel`  in  2  A source: 00 rs1, 01 pc, 10 zero, 11 reserved (treated as zero).
- `in_b_sel`  in  1  B source: 0 rs2, 1 imm.
- `in_reg_write`  in  1  instruction writes `rd`.
- `flush`  in  1  kill held and incoming instruction.
- `exmem_reg_write`, `exmem_rd`, `exmem_result`  in  1/5/XLEN  EX/MEM forward source.
- `memwb_reg_write`, `memwb_rd`, `memwb_result`  in  1/5/XLEN  MEM/WB forward source.
- `out_valid`  out  1  registered instruction is valid.
- `out_ready`  in  1  execute consumes this cycle.
- `A`, `B`  out  XLEN, signed  ALU operands.
- `ALUOp`  out  5  ALU opcode.
- `out_rd`, `out_reg_write`  out  5/1  carried to later stages.

## Operation
- Reset: `out_valid`=0, `A`=`B`=0, `ALUOp`=nop (5'b00000), `out_rd`=0, `out_reg_write`=0.
- `in_ready` = !`out_valid` || `out_ready` (combinational, no bubble on continuous flow).
- Capture when `in_valid && in_ready && !flush`: all output registers load next edge and `out_valid`=1.
- `out_valid && out_ready` with no capture: `out_valid`→0. Other output registers hold.
- Stall (`out_valid && !out_ready`): all outputs hold. Input is not accepted.
- `flush`: `out_valid`→0 next edge. Incoming instruction is dropped even if handshake true. Flush has priority over capture and stall.
- Forwarding per source register r (computed at capture):
  - If r≠0 and `exmem_reg_write` and `exmem_rd`==r, use `exmem_result`.
  - Otherwise, if r≠0 and `memwb_reg_write` and `memwb_rd`==r, use `memwb_result`.
  - Otherwise use register data.
  - EX/MEM always wins over MEM/WB.
- A = forwarded rs1 / `in_pc` / 0 per `in_a_sel`. B = forwarded rs2 / `in_imm` per `in_b_sel`.
- lui: decode drives a_sel=zero, b_sel=imm. auipc: a_sel=pc, b_sel=imm.
- Operands captured during a stall are frozen. The hazard unit guarantees no producer retires unseen while stalled.
- Invalid bubble (`out_valid`=0): `ALUOp` keeps its last value. Consumers gate on `out_valid`.

## Timing
- Latency 1 cycle input→output. Throughput 1/cycle.
- Only `in_ready` is combinational (from `out_valid`, `out_ready`). Every other output is a flop.
- Async reset asserted mid-stall clears `out_valid` immediately. First capture can occur on the first edge after deassertion.

## Configuration
- `ID_EX_FWD_EN` defined: forwarding logic as above.
- `ID_EX_FWD_EN` undefined: rs1/rs2 operands come directly from `in_rs1_data`/`in_rs2_data`. Forward ports remain but are ignored. Software or the hazard unit inserts stalls instead.

## Structure
- Shared package `cpu_pkg` holds:
  - ALU opcode constants (`ALUOp_nop`=0, `lui`=1, `auipc`=2, `add`=3, `sub`=4).
  - A-select encodings (RS1/PC/ZERO).
  - B-select encodings (RS2/IMM).
- One sub-module, `fwd_mux`: takes a source index, register data and both forward sources, and returns the resolved operand. It is instantiated twice (rs1, rs2).

## Test plan
- Reset: assert `rst` with `in_valid`=1 → `out_valid`=0, `A`=`B`=0, `ALUOp`=0 while reset is held.
- Forward priority: rs1=5, `exmem_rd`=5 result 0x11, `memwb_rd`=5 result 0x22, add → `A`=0x11 next cycle.
- x0 guard: rs2=0, `exmem_rd`=0 `reg_write`=1 result 0xFF, b_sel=rs2, rs2_data=0 → `B`=0.
- Stall: capture sub A=7 B=3, then hold `out_ready`=0 for 3 cycles with new inputs → outputs unchanged, `in_ready`=0. Release → new instruction loads next edge.
- Flush during capture: `in_valid`=1, `in_ready`=1, `flush`=1 → `out_valid`=0 next cycle, instruction lost.
- auipc/lui: pc=0x1000, imm=0x2000. auipc → `A`=0x1000, `B`=0x2000, `ALUOp`=2. lui → `A`=0, `ALUOp`=1.
